// File: rtl/pie_downlink_decoder.sv
// PIE downlink decoder: synchronise and deglitch DEC_IN, time the intervals, decode bytes and frame strobes.
// Optional CRC-8 frame check is compiled in when PIE_DEC_CRC8_EN is defined.
module pie_downlink_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GLITCH_CYC  = 3,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned DELIM_MIN   = 250,
    parameter int unsigned BIT_THRESH  = 60,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic       CLKA,
    input  logic       RST,
    input  logic       DEC_IN,
    input  logic       ED_EN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VLD,
    output logic       FRAME_SOF,
    output logic       FRAME_EOF,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
    localparam logic [GW-1:0]    GLITCH_LAST = GW'(GLITCH_CYC - 1);
    localparam logic [CNT_W-1:0] DELIM_C     = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] BIT_C       = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, DELIM, HIGH, LOW, LOST} state_t;

    state_t             state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic [GW-1:0]      glitch_cnt;
    logic               f, f_d, rise, fall;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift, byte_val;
    logic               has_byte, bit_val, byte_done, crc_bad;
    logic               sof_c, eof_c, err_c, shift_en, abort_c, busy_nxt;

    always_ff @(posedge CLKA) begin
        if (RST) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], DEC_IN};
    end

    always_ff @(posedge CLKA) begin
        if (RST) begin
            f          <= 1'b1;
            f_d        <= 1'b1;
            glitch_cnt <= '0;
        end else begin
            f_d <= f;
            if (sync[SYNC_STAGES-1] == f) begin
                glitch_cnt <= '0;
            end else if (glitch_cnt == GLITCH_LAST) begin
                f          <= sync[SYNC_STAGES-1];
                glitch_cnt <= '0;
            end else begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end

    assign rise = f & ~f_d;
    assign fall = ~f & f_d;

    // cnt equals the width of the level just ended when rise/fall is seen
    always_ff @(posedge CLKA) begin
        if (RST)              cnt <= '0;
        else if (rise | fall) cnt <= CNT_W'(1);
        else if (cnt != '1)   cnt <= cnt + 1'b1;
    end

    always_ff @(posedge CLKA) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ED_EN) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (fall) state_nxt = DELIM;
                DELIM: begin
                    if (rise)                 state_nxt = (cnt >= DELIM_C) ? HIGH : IDLE;
                    else if (cnt > TIMEOUT_C) state_nxt = LOST;
                end
                HIGH: begin
                    if (fall)                 state_nxt = LOW;
                    else if (cnt > TIMEOUT_C) state_nxt = IDLE;
                end
                // An over-long low restarts as a delimiter; a rise on that same cycle is its end
                LOW: begin
                    if (cnt >= DELIM_C)       state_nxt = rise ? HIGH : DELIM;
                    else if (rise)            state_nxt = HIGH;
                end
                LOST:  if (rise) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        sof_c    = 1'b0;
        eof_c    = 1'b0;
        err_c    = 1'b0;
        shift_en = 1'b0;
        abort_c  = 1'b0;
        busy_nxt = BUSY;
        if (!ED_EN) begin
            err_c    = BUSY;
            busy_nxt = 1'b0;
        end else begin
            unique case (state)
                DELIM: begin
                    if (rise && cnt >= DELIM_C) begin
                        sof_c    = 1'b1;
                        busy_nxt = 1'b1;
                    end else if (!rise && cnt > TIMEOUT_C) begin
                        err_c    = BUSY;
                        busy_nxt = 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        shift_en = 1'b1;
                    end else if (cnt > TIMEOUT_C) begin
                        eof_c    = 1'b1;
                        err_c    = (bit_cnt != 3'd0) || !has_byte || crc_bad;
                        busy_nxt = 1'b0;
                    end
                end
                LOW: begin
                    if (cnt >= DELIM_C) begin
                        abort_c  = 1'b1;
                        err_c    = 1'b1;
                        busy_nxt = rise;
                        sof_c    = rise;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bit_val   = (cnt > BIT_C);
    assign byte_val  = {shift[6:0], bit_val};
    assign byte_done = shift_en && (bit_cnt == 3'd7);

    always_ff @(posedge CLKA) begin
        if (RST) begin
            DATA_OUT  <= '0;
            DATA_VLD  <= 1'b0;
            FRAME_SOF <= 1'b0;
            FRAME_EOF <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            has_byte  <= 1'b0;
        end else begin
            DATA_VLD  <= byte_done;
            FRAME_SOF <= sof_c;
            FRAME_EOF <= eof_c;
            FRAME_ERR <= err_c;
            BUSY      <= busy_nxt;
            if (sof_c || abort_c) begin
                shift    <= '0;
                bit_cnt  <= '0;
                has_byte <= 1'b0;
            end else if (shift_en) begin
                shift   <= byte_val;
                bit_cnt <= bit_cnt + 1'b1;
                if (byte_done) begin
                    DATA_OUT <= byte_val;
                    has_byte <= 1'b1;
                end
            end
        end
    end

`ifdef PIE_DEC_CRC8_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge CLKA) begin
        if (RST || sof_c)   crc <= '0;
        else if (byte_done) crc <= crc8_next(crc, byte_val);
    end

    assign crc_bad = (crc != 8'h00);
`else
    assign crc_bad = 1'b0;
`endif

endmodule

// File: doc/pie_downlink_decoder.md
Name: pie_downlink_decoder

Overview:
- Downlink decoder directly downstream of the envelope detector input DEC_IN on the 20 MHz CLKA domain.
- Demodulates pulse-interval-encoded (PIE) frames: a long low delimiter, then data symbols, each a high interval followed by a short low pulse.
- Emits decoded bytes plus frame start/end/error strobes to the backscatter control logic that drives D901/D919.
- Runs only while ED_EN is high.

Parameters:
SYNC_STAGES, 2, flops in the DEC_IN synchroniser (min 2)
GLITCH_CYC, 3, consecutive equal synced samples required before the filtered level changes
CNT_W, 12, width of the interval counter; saturates at all-ones
DELIM_MIN, 250, low width in cycles at or above which a low is a delimiter
BIT_THRESH, 60, high width in cycles at or below which a symbol is 0; above it, 1
TIMEOUT, 1000, high or low width in cycles above which a frame ends or aborts

Ports:
CLKA  input  1  system clock, 20 MHz
RST  input  1  synchronous, active-high reset
DEC_IN  input  1  asynchronous envelope-detector output; high = carrier
ED_EN  input  1  decoder enable; low forces IDLE
DATA_OUT  output  8  last decoded byte, MSB first; held until next byte
DATA_VLD  output  1  one-cycle strobe, DATA_OUT updated
FRAME_SOF  output  1  one-cycle strobe on delimiter accepted
FRAME_EOF  output  1  one-cycle strobe at frame end
FRAME_ERR  output  1  one-cycle strobe coincident with FRAME_EOF on a bad frame, or alone on abort
BUSY  output  1  high from SOF until EOF or abort

Behaviour:
- Reset: all outputs 0, synchroniser and filter preset to 1, state IDLE, counters 0. Reset mid-frame drops the frame silently: no EOF and no ERR.
- Filter: the filtered level f changes only after synced DEC_IN holds the opposite value for GLITCH_CYC cycles. Latency from DEC_IN to f is SYNC_STAGES+GLITCH_CYC cycles.
- An interval counter counts cycles since the last f edge. It clears on each edge and saturates.
- States:
  - IDLE: wait for f fall, then go to DELIM.
  - DELIM:
    - f rise with count >= DELIM_MIN: SOF, BUSY=1, go to HIGH.
    - f rise with count < DELIM_MIN: go to IDLE.
    - count > TIMEOUT: go to LOST.
  - HIGH:
    - f fall: decode the bit (count <= BIT_THRESH gives 0, else 1) and shift it in; go to LOW.
    - count > TIMEOUT: end of frame. EOF is asserted. ERR is also asserted if bit count mod 8 != 0 or the frame held zero bytes. Go to IDLE.
  - LOW:
    - f rise with count < DELIM_MIN: go to HIGH.
    - count reaches DELIM_MIN while low: the in-progress frame is aborted (ERR strobe, partial bits discarded) and it is treated as a new delimiter, so go to DELIM with the count preserved.
  - LOST: wait for f rise, then go to IDLE. On entry from an active frame, ERR strobes.
- Byte output: on the 8th shifted bit, DATA_OUT<=shift register and DATA_VLD=1 on the cycle after the f fall that ended the 8th high interval. The bit counter then wraps to 0.
- Simultaneous events: EOF and ERR in the same cycle are legal. DATA_VLD never coincides with EOF because they are separated by at least TIMEOUT cycles.
- ED_EN low: next cycle state IDLE and BUSY=0. If BUSY was 1, ERR strobes once. DATA_OUT is retained.
- Counter widths: CNT_W must hold TIMEOUT+1. Comparisons are unsigned.

Optional Feature:
- Macro: PIE_DEC_CRC8_EN.
- When defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB first) runs over every decoded byte of the frame.
  - The last byte is the transmitted CRC.
  - At EOF, ERR is also asserted if the residue != 0x00.
  - The residue is cleared at SOF.
- When undefined: no CRC logic, and ERR depends only on length and abort rules.

Test Plan:
- Delimiter low 300 cycles, then 8 symbols with highs 80,40,80,40,40,80,40,80 and lows 20, then high 1200 cycles. Required response: SOF once; DATA_OUT=0xA5 with one DATA_VLD; EOF with ERR=0; BUSY low after EOF.
- Same frame with 2-cycle low glitches injected in the middle of each high. Required response: identical output, 0xA5 and no ERR.
- Delimiter followed by only 5 symbols, then idle high. Required response: no DATA_VLD; EOF and ERR in the same cycle.
- Mid-frame after 3 bytes, a low of 300 cycles, then a valid 1-byte frame 0x3C. Required response: ERR strobe alone, then SOF; DATA_OUT=0x3C; clean EOF.
- ED_EN drops mid-byte. Required response: one ERR strobe, BUSY=0; no DATA_VLD afterwards. RST pulse mid-frame: all outputs 0 next cycle, no EOF.
- With PIE_DEC_CRC8_EN defined, frame 0x01 0x07. Required response: EOF, ERR=0. Frame 0x01 0x08: EOF with ERR=1.
